// File: rtl/ilowx_blk_fetch.sv
// ilowx_blk_fetch
//   Lower-memory responder of the ilowX block interface used by the
//   instruction cache. It takes one block request at a time and reads the
//   block word by word from a single-outstanding memory port. It assembles
//   the words and returns the block on the ilowX response channel. An
//   uncached request reads only the addressed word and leaves the other
//   lanes zero.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), async active-low reset
//   lx_req_*             ilowX request: valid/ready, byte address, uncached flag
//   lx_res_*             ilowX response: valid/ready, assembled block
//   mem_req_*            word read request: valid/ready, 4-byte aligned address
//   mem_rsp_*            word read data: valid, data
//
// Every output comes straight from a flop. The registered outputs are
// loaded from the next-state values, so they line up with the state they
// belong to.
module ilowx_blk_fetch #(
  parameter int XLEN     = 32,
  parameter int BLK_SIZE = 128
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                lx_req_valid_i,
  output logic                lx_req_ready_o,
  input  logic [XLEN-1:0]     lx_req_addr_i,
  input  logic                lx_req_uncached_i,
  output logic                lx_res_valid_o,
  input  logic                lx_res_ready_i,
  output logic [BLK_SIZE-1:0] lx_res_blk_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [XLEN-1:0]     mem_req_addr_o,
  input  logic                mem_rsp_valid_i,
  input  logic [XLEN-1:0]     mem_rsp_data_i
);

  localparam int WORDS  = BLK_SIZE / XLEN;
  localparam int OFS    = $clog2(BLK_SIZE / 8);
  localparam int LANE_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [LANE_W-1:0]   beat_r, beat_s;
  logic [XLEN-1:0]     base_r, base_s;
  logic                unc_r, unc_s;
  logic [BLK_SIZE-1:0] buf_r, buf_s;
  logic [LANE_W-1:0]   lane_s;
  logic [XLEN-1:0]     addr_s;

  logic                req_ready_r;
  logic                res_valid_r;
  logic                mem_valid_r;
  logic [XLEN-1:0]     mem_addr_r;

  // Next-state logic: FSM transitions, beat/base capture and lane fill
  always_comb begin
    state_s = state_r;
    beat_s  = beat_r;
    base_s  = base_r;
    unc_s   = unc_r;
    buf_s   = buf_r;
    // An uncached word lands in the lane its address selects within the block
    if (unc_r) begin
      lane_s = base_r[2 +: LANE_W];
    end else begin
      lane_s = beat_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (lx_req_valid_i && req_ready_r) begin
          unc_s  = lx_req_uncached_i;
          beat_s = {LANE_W{1'b0}};
          buf_s  = {BLK_SIZE{1'b0}};
          if (lx_req_uncached_i) begin
            base_s = lx_req_addr_i & ~XLEN'(3);
          end else begin
            base_s = lx_req_addr_i & ~XLEN'((BLK_SIZE / 8) - 1);
          end
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Read data is not looked at here, even if it arrives with the handshake
        if (mem_req_ready_i && mem_valid_r) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid_i) begin
          for (int i = 0; i < WORDS; i++) begin
            if (lane_s == LANE_W'(i)) begin
              buf_s[i*XLEN +: XLEN] = mem_rsp_data_i;
            end else begin
              buf_s[i*XLEN +: XLEN] = buf_r[i*XLEN +: XLEN];
            end
          end
          if (unc_r || (beat_r == LANE_W'(WORDS - 1))) begin
            state_s = ST_RESP;
          end else begin
            beat_s  = beat_r + LANE_W'(1);
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (lx_res_ready_i && res_valid_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Word address for the next memory read; a cached base is block-aligned, so the offset never carries out of the block
  always_comb begin
    if (unc_s) begin
      addr_s = base_s;
    end else begin
      addr_s = base_s + XLEN'({beat_s, 2'b00});
    end
  end

  // State, beat counter, base address, uncached flag and block buffer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      beat_r  <= {LANE_W{1'b0}};
      base_r  <= {XLEN{1'b0}};
      unc_r   <= 1'b0;
      buf_r   <= {BLK_SIZE{1'b0}};
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
      base_r  <= base_s;
      unc_r   <= unc_s;
      buf_r   <= buf_s;
    end
  end

  // Registered handshake outputs, decoded from the state being entered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_ready_r <= 1'b0;
      res_valid_r <= 1'b0;
      mem_valid_r <= 1'b0;
      mem_addr_r  <= {XLEN{1'b0}};
    end else begin
      req_ready_r <= (state_s == ST_IDLE);
      res_valid_r <= (state_s == ST_RESP);
      mem_valid_r <= (state_s == ST_ISSUE);
      if (state_s == ST_ISSUE) begin
        mem_addr_r <= addr_s;
      end else begin
        mem_addr_r <= {XLEN{1'b0}};
      end
    end
  end

  assign lx_req_ready_o  = req_ready_r;
  assign lx_res_valid_o  = res_valid_r;
  assign lx_res_blk_o    = buf_r;
  assign mem_req_valid_o = mem_valid_r;
  assign mem_req_addr_o  = mem_addr_r;

endmodule
